// File: rtl/i2s_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_clkgen
// Master-mode I2S clock generator. Produces the serial clock (SCK), the word
// select (WS) and a once-per-stereo-frame pulse, with a clean stop that always
// completes the frame in progress.
//
// Ports:
//   clk_i      system clock, all logic on its rising edge
//   rst_n_i    asynchronous active-low reset
//   en_i       run request; dropping it stops at the next frame boundary
//   div_i      SCK half-period minus one, in clk_i cycles
//   chl_i      channel length code, L = 8*(chl_i+1) SCK periods per channel
//   fmt_i      WS format: 00 I2S, 01 left-justified, 10 PCM short sync, 11 as 00
//   i2s_sck_o  generated serial clock
//   i2s_ws_o   generated word select
//   busy_o     high whenever the generator is not idle
//   frame_o    one-cycle pulse at the end of every complete stereo frame
// ---------------------------------------------------------------------------
module i2s_clkgen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           chl_i,
  input  logic [1:0]           fmt_i,
  output logic                 i2s_sck_o,
  output logic                 i2s_ws_o,
  output logic                 busy_o,
  output logic                 frame_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Configuration captured on the IDLE->RUN transition only
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           chl_q;
  logic [1:0]           fmt_q;

  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [4:0]           bit_cnt_q;
  logic                 chan_q;
  logic                 sck_q;
  logic                 ws_q;
  logic                 busy_q;
  logic                 frame_q;

  logic half_tick;
  logic fall_tick;
  logic bit_last;
  logic frame_end;

  // WS level for a given channel/bit position under a given format
  function automatic logic ws_value(input logic [1:0] fmt, input logic chan,
                                    input logic bit_zero);
    case (fmt)
      2'b01:   ws_value = ~chan;
      2'b10:   ws_value = ~chan & bit_zero;
      default: ws_value = chan;
    endcase
  endfunction

  // L-1 = 8*(chl+1)-1, which is simply {chl, 3'b111}
  assign half_tick = (div_cnt_q == div_q);
  assign fall_tick = half_tick & sck_q;
  assign bit_last  = (bit_cnt_q == {chl_q, 3'b111});
  assign frame_end = fall_tick & bit_last & chan_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A stop is only honoured at the frame end, and only if
  // the run request is still low then, so a short en_i dip is invisible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = RUN;
      end
      RUN: begin
        if (frame_end && !en_i) state_d = IDLE;
        else if (!en_i)         state_d = STOP;
      end
      STOP: begin
        if (frame_end && !en_i) state_d = IDLE;
        else if (en_i)          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Every counter wraps to zero exactly at the frame end, so the
  // return to IDLE leaves SCK low and the counters already cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q     <= '0;
      chl_q     <= 2'b00;
      fmt_q     <= 2'b00;
      div_cnt_q <= '0;
      bit_cnt_q <= 5'd0;
      chan_q    <= 1'b0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      frame_q <= frame_end;
      if (state_q == IDLE) begin
        if (en_i) begin
          div_q     <= div_i;
          chl_q     <= chl_i;
          fmt_q     <= fmt_i;
          div_cnt_q <= '0;
          bit_cnt_q <= 5'd0;
          chan_q    <= 1'b0;
          sck_q     <= 1'b0;
          ws_q      <= ws_value(fmt_i, 1'b0, 1'b1);
        end
      end else if (half_tick) begin
        div_cnt_q <= '0;
        sck_q     <= ~sck_q;
        if (sck_q) begin
          if (bit_last) begin
            bit_cnt_q <= 5'd0;
            chan_q    <= ~chan_q;
            ws_q      <= ws_value(fmt_q, ~chan_q, 1'b1);
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            ws_q      <= ws_value(fmt_q, chan_q, 1'b0);
          end
        end
      end else begin
        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  assign i2s_sck_o = sck_q;
  assign i2s_ws_o  = ws_q;
  assign busy_o    = busy_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_i2s_clkgen.sv
// ---------------------------------------------------------------------------
// tb_i2s_clkgen
// Self-checking bench for i2s_clkgen. The reference model tracks only the
// cycle index since the start of the current run and the latched config, and
// derives SCK/WS/frame from that index with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_i2s_clkgen;

  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          en_i;
  logic [DW-1:0] div_i;
  logic [1:0]    chl_i;
  logic [1:0]    fmt_i;
  logic          i2s_sck_o;
  logic          i2s_ws_o;
  logic          busy_o;
  logic          frame_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_active;
  int m_t;
  int m_div;
  int m_len;
  int m_fmt;
  bit m_idle_ws;
  bit m_frame;

  i2s_clkgen #(.DIV_WIDTH(DW)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (en_i),
    .div_i     (div_i),
    .chl_i     (chl_i),
    .fmt_i     (fmt_i),
    .i2s_sck_o (i2s_sck_o),
    .i2s_ws_o  (i2s_ws_o),
    .busy_o    (busy_o),
    .frame_o   (frame_o)
  );

  always #5 clk_i = ~clk_i;

  // WS level by format for a channel (0 = left) and bit index
  function automatic bit ws_of(int fmt, int chan, int bitn);
    case (fmt)
      1:       return (chan == 0);
      2:       return (chan == 0) && (bitn == 0);
      default: return (chan == 1);
    endcase
  endfunction

  function automatic int frame_len();
    return 4 * m_len * (m_div + 1);
  endfunction

  // Advance the model across one rising edge using the inputs seen there
  task automatic modelEdge();
    if (!m_active) begin
      m_frame = 1'b0;
      if (en_i) begin
        m_active = 1'b1;
        m_t      = 0;
        m_div    = int'(div_i);
        m_len    = 8 * (int'(chl_i) + 1);
        m_fmt    = int'(fmt_i);
      end
    end else if ((m_t % frame_len()) == frame_len() - 1 && !en_i) begin
      m_active  = 1'b0;
      m_idle_ws = ws_of(m_fmt, 0, 0);
      m_frame   = 1'b1;
    end else begin
      m_t     = m_t + 1;
      m_frame = ((m_t % frame_len()) == 0);
    end
  endtask

  task automatic modelReset();
    m_active  = 1'b0;
    m_t       = 0;
    m_idle_ws = 1'b0;
    m_frame   = 1'b0;
  endtask

  task automatic checkOutput(string tag);
    logic exp_sck, exp_ws, exp_busy, exp_frame;
    int   h, p;
    if (m_active) begin
      h        = m_t / (m_div + 1);
      p        = (h / 2) % (2 * m_len);
      exp_sck  = logic'(h % 2);
      exp_ws   = ws_of(m_fmt, p / m_len, p % m_len);
      exp_busy = 1'b1;
    end else begin
      exp_sck  = 1'b0;
      exp_ws   = m_idle_ws;
      exp_busy = 1'b0;
    end
    exp_frame = m_frame;
    checks++;
    assert (i2s_sck_o === exp_sck) else begin
      errors++;
      $error("[TB] FAIL %s sck: observed %b expected %b (t=%0d)", tag, i2s_sck_o, exp_sck, m_t);
    end
    checks++;
    assert (i2s_ws_o === exp_ws) else begin
      errors++;
      $error("[TB] FAIL %s ws: observed %b expected %b (t=%0d)", tag, i2s_ws_o, exp_ws, m_t);
    end
    checks++;
    assert (busy_o === exp_busy) else begin
      errors++;
      $error("[TB] FAIL %s busy: observed %b expected %b (t=%0d)", tag, busy_o, exp_busy, m_t);
    end
    checks++;
    assert (frame_o === exp_frame) else begin
      errors++;
      $error("[TB] FAIL %s frame: observed %b expected %b (t=%0d)", tag, frame_o, exp_frame, m_t);
    end
  endtask

  // Hold the given inputs for a number of cycles, checking after every edge
  task automatic applyStimulus(string tag, bit en, int div, int chl, int fmt, int cycles);
    for (int n = 0; n < cycles; n++) begin
      en_i  = en;
      div_i = DW'(div);
      chl_i = 2'(chl);
      fmt_i = 2'(fmt);
      @(posedge clk_i);
      modelEdge();
      #1;
      checkOutput(tag);
    end
  endtask

  // Fresh random inputs every cycle; config churn while running must be ignored
  task automatic randomStimulus(string tag, int cycles);
    for (int n = 0; n < cycles; n++) begin
      en_i  = ($urandom_range(0, 99) < 85);
      div_i = DW'($urandom_range(0, 3));
      chl_i = 2'($urandom_range(0, 3));
      fmt_i = 2'($urandom_range(0, 3));
      @(posedge clk_i);
      modelEdge();
      #1;
      checkOutput(tag);
    end
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock
  task automatic resetPulse(string tag);
    #2;
    rst_n_i = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    @(posedge clk_i);
    #1;
    checkOutput(tag);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    div_i   = '0;
    chl_i   = 2'b00;
    fmt_i   = 2'b00;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    applyStimulus("idle_wait", 0, 1, 0, 0, 5);
    // 4-clk SCK, 64-clk frame, standard I2S
    applyStimulus("i2s_div1", 1, 1, 0, 0, 200);
    // Drop en mid-frame: must finish the frame then idle with SCK low
    applyStimulus("stop_i2s", 0, 1, 0, 0, 100);
    // PCM short frame sync
    applyStimulus("pcm_div1", 1, 1, 0, 2, 140);
    applyStimulus("stop_pcm", 0, 1, 0, 2, 80);
    // Left-justified, 2-clk SCK, 32-bit channels
    applyStimulus("lj_div0", 1, 0, 3, 1, 150);
    // Short en dip within a frame must not interrupt anything
    applyStimulus("en_dip", 0, 0, 3, 1, 3);
    applyStimulus("en_dip_resume", 1, 0, 3, 1, 60);
    // Config change while running is ignored until restart
    applyStimulus("div_change", 1, 3, 3, 1, 100);
    applyStimulus("stop_div", 0, 3, 0, 0, 200);
    applyStimulus("restart_div3", 1, 3, 0, 0, 300);
    applyStimulus("fmt3", 1, 3, 1, 3, 40);
    // Reset mid-frame, then a full first frame afterwards
    resetPulse("reset_mid");
    applyStimulus("post_reset", 1, 1, 1, 0, 300);
    applyStimulus("stop_post_reset", 0, 1, 1, 0, 140);
    randomStimulus("random_a", 5000);
    resetPulse("reset_rand");
    randomStimulus("random_b", 5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
